// File: rtl/sd_block_writer_if.sv
// Host-side request and block-data bus of the SD single-block writer.
interface sd_block_writer_if;
    logic        write_req;
    logic [31:0] block_addr;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic        busy;
    logic        write_complete;
    logic        error;
    logic [2:0]  err_code;

    modport master (
        output write_req, block_addr, wdata, wdata_valid,
        input  wdata_ready, busy, write_complete, error, err_code
    );

    modport slave (
        input  write_req, block_addr, wdata, wdata_valid,
        output wdata_ready, busy, write_complete, error, err_code
    );
endinterface

// File: rtl/sd_block_writer.sv
// SD card single-block write (CMD24) over SPI mode 0.
// A byte-slot shifter moves 8 bits out/in per slot; the FSM picks the byte
// to send and reacts to the byte received when each slot completes.
module sd_block_writer #(
    parameter int CLK_DIV      = 4,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             initialized,
    sd_block_writer_if.slave bus,
    output logic             sd_clk,
    output logic             sdCs,
    output logic             sd_Data_IR,
    input  logic             sdDataBack
);
    typedef enum logic [3:0] {
        IDLE, CMD, R1, GAP, TOKEN, DATA, CRC, DRESP, BUSYW, TAIL, DONE
    } state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [15:0] BUSY_LAST = 16'(BUSY_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  err_q, err_d;
    logic [31:0] addr_q, hold_q;
    logic        hold_full_q;
    logic [7:0]  words_q;
    logic        busy_q, wc_q, error_q, cs_q;
    // byte-slot shifter
    logic        sh_act_q, sck_q, mosi_q;
    logic [7:0]  div_q, rx_q;
    logic [2:0]  bit_q;
    logic [6:0]  tx_q;

    logic        accept, wxfer, byte_done, slot_start, data_win;
    logic [7:0]  slot_byte;

    assign accept    = (state_q == IDLE) && bus.write_req && initialized;
    // last falling edge of the 8th bit; rx_q already holds the full byte
    assign byte_done = sh_act_q && sck_q && (div_q == DIV_LAST) && (bit_q == 3'd7);
    assign data_win  = (state_q == GAP) || (state_q == TOKEN) || (state_q == DATA);

    assign bus.wdata_ready    = !hold_full_q && data_win && (words_q != 8'd128);
    assign wxfer              = bus.wdata_valid && bus.wdata_ready;
    assign bus.busy           = busy_q;
    assign bus.write_complete = wc_q;
    assign bus.error          = error_q;
    assign bus.err_code       = err_q;
    assign sd_clk             = sck_q;
    assign sdCs               = cs_q;
    assign sd_Data_IR         = mosi_q;

    // FSM state register and per-state slot counter
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: advances only when a byte slot finishes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE:  if (accept) begin state_d = CMD; cnt_d = '0; err_d = '0; end
            CMD:   if (byte_done) begin
                       if (cnt_q == 16'd5) begin state_d = R1; cnt_d = '0; end
                       else cnt_d = cnt_q + 16'd1;
                   end
            R1:    if (byte_done) begin
                       if (rx_q == 8'h00)             state_d = GAP;
                       else if (rx_q != 8'hFF)        begin state_d = TAIL; err_d = 3'd2; end
                       else if (cnt_q == 16'd7)       begin state_d = TAIL; err_d = 3'd1; end
                       else                           cnt_d = cnt_q + 16'd1;
                   end
            GAP:   if (byte_done) state_d = TOKEN;
            TOKEN: if (byte_done) begin state_d = DATA; cnt_d = '0; end
            DATA:  if (byte_done) begin
                       if (cnt_q == 16'd511) begin state_d = CRC; cnt_d = '0; end
                       else cnt_d = cnt_q + 16'd1;
                   end
            CRC:   if (byte_done) begin
                       if (cnt_q == 16'd1) state_d = DRESP;
                       else cnt_d = cnt_q + 16'd1;
                   end
            DRESP: if (byte_done) begin
                       cnt_d = '0;
                       if (rx_q[4:0] == 5'b00101) state_d = BUSYW;
                       else begin state_d = TAIL; err_d = 3'd3; end
                   end
            BUSYW: if (byte_done) begin
                       if (rx_q == 8'hFF)            state_d = TAIL;
                       else if (cnt_q == BUSY_LAST)  begin state_d = TAIL; err_d = 3'd4; end
                       else                          cnt_d = cnt_q + 16'd1;
                   end
            TAIL:  if (byte_done) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slot byte and slot start; DATA slots wait (sd_clk low) for a full holding register
    always_comb begin
        slot_byte  = 8'hFF;
        slot_start = 1'b0;
        case (state_q)
            CMD: case (cnt_q[2:0])
                     3'd0:    slot_byte = 8'h58;
                     3'd1:    slot_byte = addr_q[31:24];
                     3'd2:    slot_byte = addr_q[23:16];
                     3'd3:    slot_byte = addr_q[15:8];
                     3'd4:    slot_byte = addr_q[7:0];
                     default: slot_byte = 8'hFF;
                 endcase
            TOKEN: slot_byte = 8'hFE;
            DATA: case (cnt_q[1:0])
                      2'd0:    slot_byte = hold_q[31:24];
                      2'd1:    slot_byte = hold_q[23:16];
                      2'd2:    slot_byte = hold_q[15:8];
                      default: slot_byte = hold_q[7:0];
                  endcase
            default: slot_byte = 8'hFF;
        endcase
        if (!sh_act_q) begin
            case (state_q)
                CMD, R1, GAP, TOKEN, CRC, DRESP, BUSYW, TAIL: slot_start = 1'b1;
                DATA:    slot_start = hold_full_q;
                default: slot_start = 1'b0;
            endcase
        end
    end

    // Request bookkeeping: busy, chip select, completion pulse and sticky error
    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q  <= '0;
            busy_q  <= 1'b0;
            wc_q    <= 1'b0;
            error_q <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            wc_q <= 1'b0;
            if (accept) begin
                addr_q  <= bus.block_addr;
                busy_q  <= 1'b1;
                error_q <= 1'b0;
                cs_q    <= 1'b0;
            end
            if (state_d == TAIL && state_q != TAIL) cs_q <= 1'b1;
            if (state_q == DONE) begin
                wc_q    <= 1'b1;
                error_q <= (err_q != 3'd0);
                busy_q  <= 1'b0;
            end
        end
    end

    // Holding register: freed once its last byte is loaded into the shifter
    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            words_q     <= '0;
        end else begin
            if (accept) begin
                hold_full_q <= 1'b0;
                words_q     <= '0;
            end else if (wxfer) begin
                hold_q      <= bus.wdata;
                hold_full_q <= 1'b1;
                words_q     <= words_q + 8'd1;
            end else if (slot_start && state_q == DATA && cnt_q[1:0] == 2'd3) begin
                hold_full_q <= 1'b0;
            end
        end
    end

    // SPI mode 0 shifter: MOSI moves on falls (or idle), MISO sampled on rises
    always_ff @(posedge clock) begin
        if (!reset) begin
            sh_act_q <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b1;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else if (slot_start) begin
            sh_act_q <= 1'b1;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            mosi_q   <= slot_byte[7];
            tx_q     <= slot_byte[6:0];
        end else if (sh_act_q) begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                sck_q <= ~sck_q;
                if (!sck_q) begin
                    rx_q <= {rx_q[6:0], sdDataBack};
                end else if (bit_q == 3'd7) begin
                    sh_act_q <= 1'b0;
                    mosi_q   <= 1'b1;
                end else begin
                    bit_q  <= bit_q + 3'd1;
                    mosi_q <= tx_q[6];
                    tx_q   <= {tx_q[5:0], 1'b0};
                end
            end else begin
                div_q <= div_q + 8'd1;
            end
        end
    end
endmodule

// File: doc/sd_block_writer.md
SD_BLOCK_WRITER -- requirements
Module: sd_block_writer

Interface
REQ-001 Parameter CLK_DIV, default 4: sd_clk half-period in clock cycles (sd_clk = clock/(2*CLK_DIV)); legal range 2..255.
REQ-002 Parameter BUSY_TIMEOUT, default 65535: maximum byte slots to wait in busy polling.
REQ-003 Port clock, input, 1: single system clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Port initialized, input, 1: card SPI-mode init complete; sourced by the SD read controller.
REQ-006 Port write_req, input, 1: start a single-block write; sampled in IDLE only.
REQ-007 Port block_addr, input, 32: CMD24 argument, latched on an accepted write_req.
REQ-008 Port wdata, input, 32: block data word; byte [31:24] is sent first.
REQ-009 Port wdata_valid, input, 1: wdata is valid.
REQ-010 Port wdata_ready, output, 1: block can accept a word; a transfer occurs when valid and ready are both high.
REQ-011 Port sd_clk, output, 1: SPI clock, mode 0, idles low.
REQ-012 Port sdCs, output, 1: card select, active-low.
REQ-013 Port sd_Data_IR, output, 1: MOSI.
REQ-014 Port sdDataBack, input, 1: MISO.
REQ-015 Port busy, output, 1: high from an accepted request until completion.
REQ-016 Port write_complete, output, 1: one-cycle pulse at the end of each request, whether it succeeds or fails.
REQ-017 Port error, output, 1: high with write_complete when the write failed; held until the next accepted request.
REQ-018 Port err_code, output, 3: 0 ok, 1 R1 timeout, 2 R1 nonzero, 3 data rejected, 4 busy timeout.

Function
REQ-019 SPI timing: MOSI changes only on sd_clk falling edges or while sd_clk is idle; MISO is sampled on sd_clk rising edges; bytes are sent and received MSB first.
REQ-020 Each byte slot shifts 8 bits out and 8 bits in at the same time; in read-only slots the block drives 0xFF.
REQ-021 FSM states and order: IDLE, CMD, R1, GAP, TOKEN, DATA, CRC, DRESP, BUSYW, TAIL, DONE.
REQ-022 IDLE: a write_req with initialized=1 is accepted. The block latches block_addr, sets busy=1, clears error/err_code, drives sdCs low, and goes to CMD on the next cycle. A write_req with initialized=0 is ignored and raises no error.
REQ-023 CMD: sends 6 bytes: 0x58, addr[31:24], addr[23:16], addr[15:8], addr[7:0], 0xFF.
REQ-024 R1: polls up to 8 slots for a byte that is not 0xFF. A received 0x00 goes to GAP. Any other received value goes to TAIL with err_code 2. If 8 slots pass with only 0xFF, go to TAIL with err_code 1.
REQ-025 GAP: sends one 0xFF byte. TOKEN: sends 0xFE.
REQ-026 DATA: sends 512 bytes from 128 words, word k carrying bytes 4k..4k+3.
REQ-027 Word buffer is one 32-bit holding register. wdata_ready=1 when the register is empty, the state is GAP, TOKEN or DATA, and fewer than 128 words have been accepted.
REQ-028 Underrun: if a DATA byte slot needs a byte and the holding register is empty, sd_clk stays low, the slot is stretched, and no bit is lost or duplicated.
REQ-029 Words offered outside the window in REQ-027, or beyond word 128, are not accepted (wdata_ready=0).
REQ-030 CRC: sends 0xFF, 0xFF.
REQ-031 DRESP: reads 1 byte. If bits[4:0]=5'b00101 go to BUSYW; otherwise go to TAIL with err_code 3.
REQ-032 BUSYW: polls slots until a received byte is 0xFF. If BUSY_TIMEOUT slots pass without 0xFF, go to TAIL with err_code 4.
REQ-033 TAIL: drives sdCs high, then sends 1 further 0xFF byte (8 clocks) with sdCs high.
REQ-034 DONE: pulses write_complete for one cycle, sets error=(err_code!=0), clears busy, and returns to IDLE.
REQ-035 write_req asserted while busy=1 is ignored.
REQ-036 initialized falling mid-transfer has no effect until DONE.

Reset
REQ-037 While reset=0 at a rising edge, on that edge: state=IDLE, sd_clk=0, sdCs=1, sd_Data_IR=1, wdata_ready=0, busy=0, write_complete=0, error=0, err_code=0, holding register empty, all counters 0.
REQ-038 Reset applied mid-transfer aborts the transfer and produces no write_complete pulse.

Verification
REQ-039 Nominal write: block_addr=0x00001234, words 0..127 = k*0x01010101, card model gives R1=0x00 in slot 2, response 0xE5, 10 busy bytes 0x00 then 0xFF. Required: MOSI sequence 58 00 00 12 34 FF, then FF FE, then 512 data bytes, then FF FF; write_complete pulses once with error=0.
REQ-040 Underrun: wdata_valid deasserted for 50 cycles before word 64. Required: sd_clk held low during the gap; the 512-byte MOSI stream is unchanged.
REQ-041 R1=0x04. Required: no 0xFE token sent; error=1, err_code=2; sdCs high before write_complete.
REQ-042 Data rejected (response 0x0B). Required: err_code=3; busy polling skipped.
REQ-043 BUSY_TIMEOUT=16, MISO held at 0x00. Required: err_code=4 after exactly 16 busy slots.
REQ-044 Reset pulled low during DATA byte 200, then write_req with initialized=0. Required: REQ-037 values on the next edge; no write_complete pulse; the following request is ignored.
